// File: rtl/snow64_bfloat16_vec_binop_dispatcher_pkg.sv
// Shared types for the vector BFloat16 BinOp dispatcher: lane geometry,
// FSM states, port bundles and lane select/insert helpers.
package snow64_bfloat16_vec_binop_dispatcher_pkg;

   localparam int LANE_WIDTH = 16;
   localparam int LANE_COUNT = 64 / LANE_WIDTH;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_vec_dispatch_e;

   typedef struct packed {
      logic        start;
      logic [63:0] a;
      logic [63:0] b;
   } port_in_vec_binop_t;

   typedef struct packed {
      logic        busy;
      logic        valid;
      logic        err;
      logic [63:0] data;
   } port_out_vec_binop_t;

   function automatic logic [15:0] get_lane(input logic [63:0] v, input int unsigned idx);
      return v[LANE_WIDTH*idx +: LANE_WIDTH];
   endfunction

   function automatic logic [63:0] put_lane(input logic [63:0] v, input int unsigned idx,
                                            input logic [15:0] d);
      logic [63:0] r;
      r = v;
      r[LANE_WIDTH*idx +: LANE_WIDTH] = d;
      return r;
   endfunction

endpackage

// File: rtl/snow64_bfloat16_vec_binop_dispatcher.sv
// Serialises one packed 4-lane BFloat16 op onto a single scalar BinOp unit
// and reassembles the per-lane results into one 64-bit word.
module snow64_bfloat16_vec_binop_dispatcher
   import snow64_bfloat16_vec_binop_dispatcher_pkg::*;
#(
   parameter int NUM_LANES      = LANE_COUNT,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_start,
   input  logic [63:0] in_a,
   input  logic [63:0] in_b,
   output logic        out_busy,
   output logic        out_valid,
   output logic        out_err,
   output logic [63:0] out_data,
   output logic        unit_start,
   output logic [15:0] unit_a,
   output logic [15:0] unit_b,
   input  logic        unit_can_accept_cmd,
   input  logic        unit_valid,
   input  logic [15:0] unit_data
);

   localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
   localparam int CW = $clog2(TIMEOUT_CYCLES);
   localparam logic [LW-1:0] LAST_LANE = LW'(NUM_LANES - 1);
   localparam logic [CW-1:0] CNT_LAST  = CW'(TIMEOUT_CYCLES - 1);

   state_vec_dispatch_e state_q, state_d;
   logic [LW-1:0]       lane_q, lane_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [63:0]         a_q, a_d, b_q, b_d, data_q, data_d;
   logic                err_q, err_d, valid_q, valid_d, start_q, start_d;
   logic [15:0]         ua_q, ua_d, ub_q, ub_d;
   logic                fresh_s;
   port_in_vec_binop_t  in_s;
   port_out_vec_binop_t out_s;

   assign in_s = '{start: in_start, a: in_a, b: in_b};

   // Next-state, lane sequencing, result capture and timeout.
   always_comb begin
      state_d = state_q;
      lane_d  = lane_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      data_d  = data_q;
      err_d   = err_q;
      start_d = 1'b0;
      // A sticky-valid unit still shows the previous lane's result during the
      // start pulse itself, so only later cycles count as a response.
      fresh_s = unit_valid && !start_q;
      case (state_q)
         ST_IDLE: begin
            if (in_s.start) begin
               a_d     = in_s.a;
               b_d     = in_s.b;
               data_d  = 64'h0;
               err_d   = 1'b0;
               lane_d  = '0;
               state_d = ST_ISSUE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            if (unit_can_accept_cmd) begin
               start_d = 1'b1;
               cnt_d   = '0;
               state_d = ST_WAIT;
            end else begin
               state_d = ST_ISSUE;
            end
         end
         ST_WAIT: begin
            if (fresh_s) begin
               data_d = put_lane(data_q, int'(lane_q), unit_data);
               if (lane_q == LAST_LANE) begin
                  state_d = ST_DONE;
               end else begin
                  lane_d = lane_q + LW'(1);
                  // Issue the next lane on the capture edge when possible to
                  // keep the two-cycle-per-lane cadence.
                  if (unit_can_accept_cmd) begin
                     start_d = 1'b1;
                     cnt_d   = '0;
                     state_d = ST_WAIT;
                  end else begin
                     state_d = ST_ISSUE;
                  end
               end
            end else if (cnt_q == CNT_LAST) begin
               err_d   = 1'b1;
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      valid_d = (state_d == ST_DONE);
      ua_d    = ua_q;
      ub_d    = ub_q;
      if ((state_d == ST_ISSUE) || start_d) begin
         ua_d = get_lane(a_d, int'(lane_d));
         ub_d = get_lane(b_d, int'(lane_d));
      end else begin
         ua_d = ua_q;
         ub_d = ub_q;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         lane_q  <= '0;
         cnt_q   <= '0;
         a_q     <= 64'h0;
         b_q     <= 64'h0;
         data_q  <= 64'h0;
         err_q   <= 1'b0;
         valid_q <= 1'b0;
         start_q <= 1'b0;
         ua_q    <= 16'h0;
         ub_q    <= 16'h0;
      end else begin
         state_q <= state_d;
         lane_q  <= lane_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         data_q  <= data_d;
         err_q   <= err_d;
         valid_q <= valid_d;
         start_q <= start_d;
         ua_q    <= ua_d;
         ub_q    <= ub_d;
      end
   end

   assign out_s = '{busy: (state_q != ST_IDLE), valid: valid_q, err: err_q, data: data_q};

   assign out_busy   = out_s.busy;
   assign out_valid  = out_s.valid;
   assign out_err    = out_s.err;
   assign out_data   = out_s.data;
   assign unit_start = start_q;
   assign unit_a     = ua_q;
   assign unit_b     = ub_q;

endmodule

// File: tb/tb_snow64_bfloat16_vec_binop_dispatcher.sv
// Directed bench: a behavioural slt unit (pulse, dropped-lane and sticky-valid
// modes) drives the dispatcher; timing is counted in edges after in_start.
module tb_snow64_bfloat16_vec_binop_dispatcher;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_start = 1'b0;
   logic [63:0] in_a = 64'h0;
   logic [63:0] in_b = 64'h0;
   logic        out_busy, out_valid, out_err;
   logic [63:0] out_data;
   logic        unit_start;
   logic [15:0] unit_a, unit_b;
   logic        unit_can_accept_cmd = 1'b1;
   logic        unit_valid;
   logic [15:0] unit_data;

   int errors = 0;
   int checks = 0;
   int start_cnt = 0;
   int dbl_cnt = 0;
   int valid_cnt = 0;
   int op_base = 0;
   bit drop_en = 1'b0;
   bit sticky_en = 1'b0;
   logic prev_start = 1'b0;

   snow64_bfloat16_vec_binop_dispatcher #(.NUM_LANES(4), .TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_start(in_start), .in_a(in_a), .in_b(in_b),
      .out_busy(out_busy), .out_valid(out_valid), .out_err(out_err), .out_data(out_data),
      .unit_start(unit_start), .unit_a(unit_a), .unit_b(unit_b),
      .unit_can_accept_cmd(unit_can_accept_cmd), .unit_valid(unit_valid), .unit_data(unit_data)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] slt16(input logic [15:0] x, input logic [15:0] y);
      logic [15:0] kx, ky;
      if ((x[14:0] == 15'h0) && (y[14:0] == 15'h0)) return 16'h0000;
      kx = x[15] ? ~x : (x | 16'h8000);
      ky = y[15] ? ~y : (y | 16'h8000);
      return (kx < ky) ? 16'h0001 : 16'h0000;
   endfunction

   // Behavioural single-cycle slt unit.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         unit_valid <= 1'b0;
         unit_data  <= 16'h0000;
      end else begin
         if (unit_start) unit_data <= slt16(unit_a, unit_b);
         if (sticky_en) unit_valid <= 1'b1;
         else if (unit_start && !(drop_en && ((start_cnt - op_base) == 2))) unit_valid <= 1'b1;
         else unit_valid <= 1'b0;
      end
   end

   // Event counters for start pulses, back-to-back starts and completions.
   always @(posedge clk) begin
      if (unit_start) start_cnt <= start_cnt + 1;
      if (unit_start && prev_start) dbl_cnt <= dbl_cnt + 1;
      prev_start <= unit_start;
      if (out_valid) valid_cnt <= valid_cnt + 1;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Accept at edge 0; returns the edge at which out_valid is first seen and
   // a mask of edges after which unit_start was high.
   task automatic run_op(input logic [63:0] a, input logic [63:0] b,
                         input int lo_first, input int lo_last, input bit extra,
                         output int lat, output logic [31:0] mask);
      lat  = -1;
      mask = 32'h0;
      op_base = start_cnt;
      in_a = a;
      in_b = b;
      in_start = 1'b1;
      tick();
      in_start = 1'b0;
      for (int k = 1; k <= 60; k++) begin
         tick();
         if (unit_start && (k < 32)) mask[k] = 1'b1;
         if (out_valid) begin
            lat = k;
            break;
         end
         if (k == lo_first - 1) unit_can_accept_cmd = 1'b0;
         if (k == lo_last) unit_can_accept_cmd = 1'b1;
         if (extra && ((k == 2) || (k == 5))) begin
            in_start = 1'b1;
            in_a = 64'hFFFF_FFFF_FFFF_FFFF;
            in_b = 64'h0;
         end
         if (extra && ((k == 3) || (k == 6))) in_start = 1'b0;
      end
      unit_can_accept_cmd = 1'b1;
      in_start = 1'b0;
   endtask

   localparam logic [63:0] A1 = 64'h0000_BF80_4000_3F80;
   localparam logic [63:0] B1 = 64'h8000_3F80_3F80_4000;
   localparam logic [63:0] R1 = 64'h0000_0001_0000_0001;

   int          lat;
   logic [31:0] mask;
   int          v0;

   initial begin
      // Reset state.
      #2;
      check("rst_busy", {63'h0, out_busy}, 64'h0);
      check("rst_valid", {63'h0, out_valid}, 64'h0);
      check("rst_err", {63'h0, out_err}, 64'h0);
      check("rst_data", out_data, 64'h0);
      check("rst_ustart", {63'h0, unit_start}, 64'h0);
      check("rst_ua", {48'h0, unit_a}, 64'h0);
      repeat (2) tick();
      rst_n = 1'b1;
      tick();

      // 1: nominal op, always-ready unit.
      v0 = valid_cnt;
      run_op(A1, B1, -10, -10, 1'b0, lat, mask);
      check("t1_lat", 64'(lat), 64'd9);
      check("t1_data", out_data, R1);
      check("t1_err", {63'h0, out_err}, 64'h0);
      check("t1_starts", {32'h0, mask}, 64'h0000_00AA);
      tick();
      check("t1_valid_drop", {63'h0, out_valid}, 64'h0);
      check("t1_busy_drop", {63'h0, out_busy}, 64'h0);
      check("t1_data_held", out_data, R1);
      check("t1_vcnt", 64'(valid_cnt - v0), 64'd1);

      // 2: unit not ready for edges 3..7.
      v0 = valid_cnt;
      run_op(A1, B1, 3, 7, 1'b0, lat, mask);
      check("t2_lat", 64'(lat), 64'd14);
      check("t2_data", out_data, R1);
      check("t2_starts", {32'h0, mask}, 64'h0000_1502);
      tick();
      check("t2_vcnt", 64'(valid_cnt - v0), 64'd1);

      // 3: lane 2 never answers, timeout of 8 cycles.
      drop_en = 1'b1;
      v0 = valid_cnt;
      run_op(64'h0000_BF80_3F80_3F80, 64'h8000_3F80_4000_4000, -10, -10, 1'b0, lat, mask);
      check("t3_lat", 64'(lat), 64'd13);
      check("t3_err", {63'h0, out_err}, 64'h1);
      check("t3_data", out_data, 64'h0000_0000_0001_0001);
      check("t3_starts", {32'h0, mask}, 64'h0000_002A);
      repeat (3) tick();
      check("t3_vcnt", 64'(valid_cnt - v0), 64'd1);
      check("t3_err_held", {63'h0, out_err}, 64'h1);
      drop_en = 1'b0;

      // 4: in_start re-pulsed while busy with different operands.
      v0 = valid_cnt;
      run_op(A1, B1, -10, -10, 1'b1, lat, mask);
      check("t4_lat", 64'(lat), 64'd9);
      check("t4_data", out_data, R1);
      check("t4_err_cleared", {63'h0, out_err}, 64'h0);
      repeat (3) tick();
      check("t4_idle", {63'h0, out_busy}, 64'h0);
      check("t4_vcnt", 64'(valid_cnt - v0), 64'd1);

      // 5: asynchronous reset between edges 4 and 5.
      v0 = valid_cnt;
      in_a = A1;
      in_b = B1;
      in_start = 1'b1;
      tick();
      in_start = 1'b0;
      repeat (4) tick();
      check("t5_pre_data", out_data, 64'h0000_0000_0000_0001);
      #2;
      rst_n = 1'b0;
      #1;
      check("t5_busy", {63'h0, out_busy}, 64'h0);
      check("t5_valid", {63'h0, out_valid}, 64'h0);
      check("t5_data", out_data, 64'h0);
      check("t5_ustart", {63'h0, unit_start}, 64'h0);
      check("t5_ua_ub", {32'h0, unit_a, unit_b}, 64'h0);
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (12) tick();
      check("t5_no_valid", 64'(valid_cnt - v0), 64'd0);
      run_op(A1, B1, -10, -10, 1'b0, lat, mask);
      check("t5_lat", 64'(lat), 64'd9);
      check("t5_fresh_data", out_data, R1);
      tick();

      // 6: sticky-valid unit; results must come from the post-start cycle.
      sticky_en = 1'b1;
      repeat (2) tick();
      run_op(64'h4000_3F80_C000_0000, 64'h3F80_3F80_BF80_3F80, -10, -10, 1'b0, lat, mask);
      check("t6_lat", 64'(lat), 64'd9);
      check("t6_data", out_data, 64'h0000_0000_0001_0001);
      check("t6_starts", {32'h0, mask}, 64'h0000_00AA);
      tick();
      sticky_en = 1'b0;

      check("no_double_start", 64'(dbl_cnt), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
